video_timing_ctl: RTL and testbench

Run-time controller for the DVI test-pattern timing generator. It holds a host-writable shadow copy of the horizontal/vertical timing, sync polarity and pattern select. It sequences generator start/stop and commits shadow to active values only on frame boundaries, so the output never sees a torn frame. It optionally auto-cycles the pattern every N frames.

---
 rtl/video_timing_pkg.sv | 59 +++++
 rtl/video_timing_ctl_if.sv | 12 +
 rtl/video_timing_regs.sv | 97 +++++++++
 rtl/video_timing_ctl.sv | 181 ++++++++++++++++++
 tb/tb_video_timing_ctl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// Register map, bit positions, FSM states and 640x480 defaults shared by the
// DVI timing controller and its register file.
package video_timing_pkg;

  localparam logic [3:0] ADDR_CTRL         = 4'd0;
  localparam logic [3:0] ADDR_H_VISIBLE    = 4'd1;
  localparam logic [3:0] ADDR_H_FRONTPORCH = 4'd2;
  localparam logic [3:0] ADDR_H_PULSE      = 4'd3;
  localparam logic [3:0] ADDR_H_BACKPORCH  = 4'd4;
  localparam logic [3:0] ADDR_V_VISIBLE    = 4'd5;
  localparam logic [3:0] ADDR_V_FRONTPORCH = 4'd6;
  localparam logic [3:0] ADDR_V_PULSE      = 4'd7;
  localparam logic [3:0] ADDR_V_BACKPORCH  = 4'd8;
  localparam logic [3:0] ADDR_POL          = 4'd9;
  localparam logic [3:0] ADDR_CYCLE_FRAMES = 4'd10;
  localparam logic [3:0] ADDR_STATUS       = 4'd15;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_APPLY  = 1;
  localparam int CTRL_AUTO   = 2;
  localparam int CTRL_PAT_LO = 4;
  localparam int CTRL_PAT_HI = 5;

  localparam int STAT_RUNNING = 0;
  localparam int STAT_PENDING = 1;
  localparam int STAT_FCNT_LO = 4;
  localparam int STAT_FCNT_HI = 15;

  localparam int VGA_H_VISIBLE    = 640;
  localparam int VGA_H_FRONTPORCH = 16;
  localparam int VGA_H_PULSE      = 96;
  localparam int VGA_H_BACKPORCH  = 48;
  localparam int VGA_V_VISIBLE    = 480;
  localparam int VGA_V_FRONTPORCH = 10;
  localparam int VGA_V_PULSE      = 2;
  localparam int VGA_V_BACKPORCH  = 33;
  localparam int VGA_CYCLE_FRAMES = 60;

  typedef enum logic [1:0] {IDLE, START, RUN, STOP_WAIT} state_t;

  typedef struct packed {
    logic [11:0] h_visible;
    logic [11:0] h_frontporch;
    logic [11:0] h_pulse;
    logic [11:0] h_backporch;
    logic [11:0] v_visible;
    logic [11:0] v_frontporch;
    logic [11:0] v_pulse;
    logic [11:0] v_backporch;
    logic        h_pol;
    logic        v_pol;
    logic [1:0]  pattern;
  } timing_t;

  function automatic logic [11:0] clamp_nonzero(input logic [11:0] v);
    return (v == 12'd0) ? 12'd1 : v;
  endfunction

endpackage

// File: rtl/video_timing_ctl_if.sv
// Host register bus of the DVI timing controller: write strobe plus
// registered-read port.
interface video_timing_ctl_if;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;

  modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
  modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/video_timing_regs.sv
// Shadow register file for the timing controller: write decode with field
// clamping and a one-cycle registered readback mux.
module video_timing_regs
  import video_timing_pkg::*;
#(
  parameter timing_t RESET_TIMING     = '0,
  parameter int      DEF_CYCLE_FRAMES = VGA_CYCLE_FRAMES
) (
  input  logic                clk,
  input  logic                reset,
  video_timing_ctl_if.slave   bus,
  input  logic                running,
  input  logic                pending,
  input  logic [11:0]         frame_cnt,
  output logic                enable,
  output logic                auto_cycle,
  output logic                apply_req,
  output timing_t             shadow,
  output logic [11:0]         cycle_frames
);

  logic [11:0] cycle_raw;
  logic [11:0] wd;
  logic [15:0] rd_q;
  logic [15:0] rd_mux;
  logic        unused_wr_bits;

  assign wd             = bus.wr_data[11:0];
  assign unused_wr_bits = ^bus.wr_data[15:12];
  assign apply_req      = bus.wr_en && (bus.wr_addr == ADDR_CTRL) && bus.wr_data[CTRL_APPLY];
  // cycle_frames keeps the written value for readback; zero behaves as one
  assign cycle_frames   = clamp_nonzero(cycle_raw);
  assign bus.rd_data    = rd_q;

  always_comb begin
    rd_mux = '0;
    case (bus.rd_addr)
      ADDR_CTRL: begin
        rd_mux[CTRL_ENABLE]             = enable;
        rd_mux[CTRL_AUTO]               = auto_cycle;
        rd_mux[CTRL_PAT_HI:CTRL_PAT_LO] = shadow.pattern;
      end
      ADDR_H_VISIBLE:    rd_mux[11:0] = shadow.h_visible;
      ADDR_H_FRONTPORCH: rd_mux[11:0] = shadow.h_frontporch;
      ADDR_H_PULSE:      rd_mux[11:0] = shadow.h_pulse;
      ADDR_H_BACKPORCH:  rd_mux[11:0] = shadow.h_backporch;
      ADDR_V_VISIBLE:    rd_mux[11:0] = shadow.v_visible;
      ADDR_V_FRONTPORCH: rd_mux[11:0] = shadow.v_frontporch;
      ADDR_V_PULSE:      rd_mux[11:0] = shadow.v_pulse;
      ADDR_V_BACKPORCH:  rd_mux[11:0] = shadow.v_backporch;
      ADDR_POL:          rd_mux[1:0]  = {shadow.v_pol, shadow.h_pol};
      ADDR_CYCLE_FRAMES: rd_mux[11:0] = cycle_raw;
      ADDR_STATUS: begin
        rd_mux[STAT_RUNNING]              = running;
        rd_mux[STAT_PENDING]              = pending;
        rd_mux[STAT_FCNT_HI:STAT_FCNT_LO] = frame_cnt;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable     <= 1'b0;
      auto_cycle <= 1'b0;
      shadow     <= RESET_TIMING;
      cycle_raw  <= 12'(DEF_CYCLE_FRAMES);
      rd_q       <= '0;
    end else begin
      rd_q <= rd_mux;
      if (bus.wr_en) begin
        case (bus.wr_addr)
          ADDR_CTRL: begin
            enable         <= bus.wr_data[CTRL_ENABLE];
            auto_cycle     <= bus.wr_data[CTRL_AUTO];
            shadow.pattern <= bus.wr_data[CTRL_PAT_HI:CTRL_PAT_LO];
          end
          ADDR_H_VISIBLE:    shadow.h_visible    <= clamp_nonzero(wd);
          ADDR_H_FRONTPORCH: shadow.h_frontporch <= wd;
          ADDR_H_PULSE:      shadow.h_pulse      <= clamp_nonzero(wd);
          ADDR_H_BACKPORCH:  shadow.h_backporch  <= wd;
          ADDR_V_VISIBLE:    shadow.v_visible    <= clamp_nonzero(wd);
          ADDR_V_FRONTPORCH: shadow.v_frontporch <= wd;
          ADDR_V_PULSE:      shadow.v_pulse      <= clamp_nonzero(wd);
          ADDR_V_BACKPORCH:  shadow.v_backporch  <= wd;
          ADDR_POL: begin
            shadow.h_pol <= bus.wr_data[0];
            shadow.v_pol <= bus.wr_data[1];
          end
          ADDR_CYCLE_FRAMES: cycle_raw <= wd;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/video_timing_ctl.sv
// DVI test-pattern timing controller: generator start/stop sequencing and
// frame-aligned commit of shadow timing, with optional pattern auto-cycling.
//
// state     | meaning
// IDLE      | generator held in reset; an apply commits on the next cycle
// START     | generator still in reset for RESET_CYCLES cycles
// RUN       | generator running; commits and auto-cycle act on frame_start
// STOP_WAIT | stop requested; generator keeps running to the frame boundary
module video_timing_ctl
  import video_timing_pkg::*;
#(
  parameter int DEF_H_VISIBLE    = VGA_H_VISIBLE,
  parameter int DEF_H_FRONTPORCH = VGA_H_FRONTPORCH,
  parameter int DEF_H_PULSE      = VGA_H_PULSE,
  parameter int DEF_H_BACKPORCH  = VGA_H_BACKPORCH,
  parameter int DEF_V_VISIBLE    = VGA_V_VISIBLE,
  parameter int DEF_V_FRONTPORCH = VGA_V_FRONTPORCH,
  parameter int DEF_V_PULSE      = VGA_V_PULSE,
  parameter int DEF_V_BACKPORCH  = VGA_V_BACKPORCH,
  parameter int DEF_CYCLE_FRAMES = VGA_CYCLE_FRAMES,
  parameter int RESET_CYCLES     = 4
) (
  input  logic              clk,
  input  logic              reset,
  video_timing_ctl_if.slave bus,
  input  logic              frame_start,
  output logic              gen_reset,
  output logic              gen_enable,
  output logic [11:0]       h_visible,
  output logic [11:0]       h_frontporch,
  output logic [11:0]       h_pulse,
  output logic [11:0]       h_backporch,
  output logic [11:0]       v_visible,
  output logic [11:0]       v_frontporch,
  output logic [11:0]       v_pulse,
  output logic [11:0]       v_backporch,
  output logic              h_sync_pol,
  output logic              v_sync_pol,
  output logic [1:0]        pattern_sel
);

  localparam int CNT_W = $clog2(RESET_CYCLES + 1);
  localparam timing_t DEF_TIMING = '{
    h_visible:    12'(DEF_H_VISIBLE),
    h_frontporch: 12'(DEF_H_FRONTPORCH),
    h_pulse:      12'(DEF_H_PULSE),
    h_backporch:  12'(DEF_H_BACKPORCH),
    v_visible:    12'(DEF_V_VISIBLE),
    v_frontporch: 12'(DEF_V_FRONTPORCH),
    v_pulse:      12'(DEF_V_PULSE),
    v_backporch:  12'(DEF_V_BACKPORCH),
    h_pol:        1'b0,
    v_pol:        1'b0,
    pattern:      2'd0
  };

  state_t           state;
  timing_t          active;
  timing_t          shadow;
  logic             pending;
  logic [11:0]      frame_cnt;
  logic [11:0]      cycle_frames;
  logic [CNT_W-1:0] rst_cnt;
  logic             enable;
  logic             auto_cycle;
  logic             apply_req;
  logic             running;
  logic             cycle_wrap;

  assign running    = (state == RUN);
  // >= so a cycle_frames shrunk below the current count still wraps promptly
  assign cycle_wrap = (frame_cnt >= cycle_frames - 12'd1);

  video_timing_regs #(
    .RESET_TIMING     (DEF_TIMING),
    .DEF_CYCLE_FRAMES (DEF_CYCLE_FRAMES)
  ) u_regs (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .running      (running),
    .pending      (pending),
    .frame_cnt    (frame_cnt),
    .enable       (enable),
    .auto_cycle   (auto_cycle),
    .apply_req    (apply_req),
    .shadow       (shadow),
    .cycle_frames (cycle_frames)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gen_reset  <= 1'b1;
      gen_enable <= 1'b0;
      active     <= DEF_TIMING;
      pending    <= 1'b0;
      frame_cnt  <= '0;
      rst_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          gen_reset  <= 1'b1;
          gen_enable <= 1'b0;
          if (enable) begin
            active  <= shadow;
            pending <= 1'b0;
            rst_cnt <= CNT_W'(RESET_CYCLES);
            state   <= START;
          end else if (pending) begin
            active  <= shadow;
            pending <= 1'b0;
          end
        end
        START: begin
          if (pending) begin
            active  <= shadow;
            pending <= 1'b0;
          end
          if (!enable) begin
            state     <= IDLE;
            frame_cnt <= '0;
          end else begin
            rst_cnt <= rst_cnt - CNT_W'(1);
            if (rst_cnt == CNT_W'(1)) begin
              state      <= RUN;
              gen_reset  <= 1'b0;
              gen_enable <= 1'b1;
            end
          end
        end
        RUN: begin
          if (frame_start) begin
            if (pending) begin
              active  <= shadow;
              pending <= 1'b0;
              if (auto_cycle) frame_cnt <= '0;
            end else if (auto_cycle) begin
              if (cycle_wrap) begin
                active.pattern <= active.pattern + 2'd1;
                frame_cnt      <= '0;
              end else begin
                frame_cnt <= frame_cnt + 12'd1;
              end
            end
          end
          if (!enable) state <= STOP_WAIT;
        end
        STOP_WAIT: begin
          if (frame_start && pending) begin
            active  <= shadow;
            pending <= 1'b0;
          end
          if (enable) begin
            state <= RUN;
          end else if (frame_start) begin
            state      <= IDLE;
            gen_enable <= 1'b0;
            gen_reset  <= 1'b1;
            frame_cnt  <= '0;
          end
        end
      endcase
      // Last assignment wins: an apply landing on a commit edge stays queued
      if (apply_req) pending <= 1'b1;
    end
  end

  assign h_visible    = active.h_visible;
  assign h_frontporch = active.h_frontporch;
  assign h_pulse      = active.h_pulse;
  assign h_backporch  = active.h_backporch;
  assign v_visible    = active.v_visible;
  assign v_frontporch = active.v_frontporch;
  assign v_pulse      = active.v_pulse;
  assign v_backporch  = active.v_backporch;
  assign h_sync_pol   = active.h_pol;
  assign v_sync_pol   = active.v_pol;
  assign pattern_sel  = active.pattern;

endmodule

// File: tb/tb_video_timing_ctl.sv
// Self-checking bench for video_timing_ctl: directed sequences, a register
// readback table and randomized traffic against a behavioural model.
module tb_video_timing_ctl;
  import video_timing_pkg::*;

  localparam int RESET_CYCLES = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_start = 1'b0;
  logic gen_reset, gen_enable;
  logic [11:0] h_visible, h_frontporch, h_pulse, h_backporch;
  logic [11:0] v_visible, v_frontporch, v_pulse, v_backporch;
  logic h_sync_pol, v_sync_pol;
  logic [1:0] pattern_sel;

  int tests = 0;
  int fails = 0;

  video_timing_ctl_if bus ();

  video_timing_ctl #(.RESET_CYCLES(RESET_CYCLES)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .frame_start  (frame_start),
    .gen_reset    (gen_reset),
    .gen_enable   (gen_enable),
    .h_visible    (h_visible),
    .h_frontporch (h_frontporch),
    .h_pulse      (h_pulse),
    .h_backporch  (h_backporch),
    .v_visible    (v_visible),
    .v_frontporch (v_frontporch),
    .v_pulse      (v_pulse),
    .v_backporch  (v_backporch),
    .h_sync_pol   (h_sync_pol),
    .v_sync_pol   (v_sync_pol),
    .pattern_sel  (pattern_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } vec_t;

  vec_t        vecs [9];
  logic [15:0] exp_reg [16];
  logic [1:0]  exp_seq [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [15:0] d);
    bus.rd_addr = a;
    tick();
    d = bus.rd_data;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_enable(input string name);
    int n;
    n = 0;
    while (gen_enable !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(name, gen_enable, 1);
  endtask

  // Stored/readback value of a register after a host write
  function automatic logic [15:0] model_store(input logic [3:0] a, input logic [15:0] d);
    logic [11:0] f;
    f = d[11:0];
    case (a)
      4'd0:                   return d & 16'h0034;
      4'd1, 4'd3, 4'd5, 4'd7: return (f == 12'd0) ? 16'd1 : {4'h0, f};
      4'd2, 4'd4, 4'd6, 4'd8,
      4'd10:                  return {4'h0, f};
      4'd9:                   return d & 16'h0003;
      default:                return 16'h0000;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    int n;
    bit ok;

    vecs[0] = '{"h_vis_wr",       4'd1,  16'd800,  16'd800};
    vecs[1] = '{"h_fp_zero",      4'd2,  16'h0000, 16'h0000};
    vecs[2] = '{"h_pulse_clamp",  4'd3,  16'h0000, 16'h0001};
    vecs[3] = '{"v_vis_mask",     4'd5,  16'hF1E0, 16'h01E0};
    vecs[4] = '{"v_pulse_clamp",  4'd7,  16'h0000, 16'h0001};
    vecs[5] = '{"pol_rd",         4'd9,  16'hFFFF, 16'h0003};
    vecs[6] = '{"ctrl_apply_rd0", 4'd0,  16'h0036, 16'h0034};
    vecs[7] = '{"unmapped_rd",    4'd12, 16'h1234, 16'h0000};
    vecs[8] = '{"cycle_rd",       4'd10, 16'd7,    16'd7};
    exp_seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};

    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;

    // Reset state
    idle(3);
    check("rst_gen_reset", gen_reset, 1);
    check("rst_gen_enable", gen_enable, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_pattern", pattern_sel, 0);
    check("rst_pol", {h_sync_pol, v_sync_pol}, 0);
    reset = 1'b0;

    // Start: one cycle for enable to register, then RESET_CYCLES in reset
    wr(ADDR_CTRL, 16'h0001);
    n = 0;
    ok = 1'b1;
    while (gen_enable !== 1'b1 && n < 20) begin
      if (gen_reset !== 1'b1) ok = 1'b0;
      tick();
      n++;
    end
    check("start_latency", n, RESET_CYCLES + 1);
    check("start_reset_held", ok, 1);
    check("start_reset_released", gen_reset, 0);
    check("start_h_timing", {h_visible, h_frontporch, h_pulse, h_backporch},
          {12'd640, 12'd16, 12'd96, 12'd48});
    check("start_v_timing", {v_visible, v_frontporch, v_pulse, v_backporch},
          {12'd480, 12'd10, 12'd2, 12'd33});

    // Apply in RUN waits for frame_start
    wr(ADDR_H_VISIBLE, 16'd800);
    wr(ADDR_CTRL, 16'h0003);
    rd(ADDR_STATUS, r);
    check("status_pending_set", r[1:0], 2'b11);
    ok = 1'b1;
    repeat (20) begin
      if (h_visible !== 12'd640) ok = 1'b0;
      tick();
    end
    check("h_vis_held_until_fs", ok, 1);
    pulse_fs();
    check("h_vis_committed", h_visible, 800);
    rd(ADDR_STATUS, r);
    check("status_pending_clr", r[1], 0);

    // Apply written in the frame_start cycle waits for the next one
    wr(ADDR_H_VISIBLE, 16'd1024);
    bus.wr_en = 1'b1;
    bus.wr_addr = ADDR_CTRL;
    bus.wr_data = 16'h0003;
    frame_start = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    frame_start = 1'b0;
    check("same_cycle_no_commit", h_visible, 800);
    rd(ADDR_STATUS, r);
    check("same_cycle_pending", r[1], 1);
    idle(3);
    pulse_fs();
    check("next_fs_commit", h_visible, 1024);

    // Auto-cycle every 3 frames
    wr(ADDR_CYCLE_FRAMES, 16'd3);
    wr(ADDR_CTRL, 16'h0005);
    for (int k = 0; k < 7; k++) begin
      pulse_fs();
      check($sformatf("auto_seq_%0d", k + 1), pattern_sel, exp_seq[k]);
      idle(2);
    end

    // Stop, re-enable before the boundary, then a real stop
    wr(ADDR_CTRL, 16'h0000);
    idle(4);
    check("stop_wait_holds", gen_enable, 1);
    wr(ADDR_CTRL, 16'h0001);
    ok = 1'b1;
    repeat (6) begin
      if (gen_enable !== 1'b1 || gen_reset !== 1'b0) ok = 1'b0;
      tick();
    end
    check("reenable_no_drop", ok, 1);
    pulse_fs();
    check("reenable_still_run", gen_enable, 1);
    wr(ADDR_CTRL, 16'h0000);
    idle(3);
    check("stop_before_fs", gen_enable, 1);
    pulse_fs();
    check("stop_after_fs_en", gen_enable, 0);
    check("stop_after_fs_rst", gen_reset, 1);

    // Register readback table (IDLE)
    foreach (vecs[i]) begin
      wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, r);
      check(vecs[i].name, r, vecs[i].rdata);
    end
    check("idle_apply_pattern", pattern_sel, 3);
    check("idle_apply_h", {h_visible, h_frontporch, h_pulse}, {12'd800, 12'd0, 12'd1});
    check("idle_apply_vp", v_pulse, 1);
    check("idle_apply_pol", {h_sync_pol, v_sync_pol}, 2'b11);

    // Randomized register traffic against the model, then commit and compare
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 41; i++) begin
        logic [3:0]  a;
        logic [15:0] d;
        a = (i < 11) ? 4'(i) : 4'($urandom_range(0, 14));
        d = ($urandom_range(0, 3) == 0) ? (16'($urandom) & 16'hF000) : 16'($urandom);
        if (a == 4'd0) d[0] = 1'b0;
        if (a == 4'd10 && d[11:0] == 12'd0) d[0] = 1'b1;
        wr(a, d);
        exp_reg[a] = model_store(a, d);
      end
      for (int a = 0; a < 15; a++) begin
        rd(4'(a), r);
        check($sformatf("rand_rd_r%0d_a%0d", round, a), r, exp_reg[a]);
      end
      wr(ADDR_CTRL, (exp_reg[0] & 16'h0034) | 16'h0002);
      idle(2);
      check("rand_h_timing", {h_visible, h_frontporch, h_pulse, h_backporch},
            {exp_reg[1][11:0], exp_reg[2][11:0], exp_reg[3][11:0], exp_reg[4][11:0]});
      check("rand_v_timing", {v_visible, v_frontporch, v_pulse, v_backporch},
            {exp_reg[5][11:0], exp_reg[6][11:0], exp_reg[7][11:0], exp_reg[8][11:0]});
      check("rand_pol", {v_sync_pol, h_sync_pol}, exp_reg[9][1:0]);
      check("rand_pattern", pattern_sel, exp_reg[0][5:4]);
    end

    // Randomized auto-cycle: pattern advances once every cf frames
    begin
      int cf, np;
      cf = $urandom_range(1, 4);
      np = $urandom_range(4, 12);
      wr(ADDR_CYCLE_FRAMES, 16'(cf));
      wr(ADDR_CTRL, 16'h0005);
      wait_enable("auto_rand_start");
      for (int k = 1; k <= np; k++) begin
        pulse_fs();
        check($sformatf("auto_rand_cf%0d_k%0d", cf, k), pattern_sel, (k / cf) % 4);
        idle($urandom_range(0, 2));
      end
      rd(ADDR_STATUS, r);
      check("auto_rand_frame_cnt", r[15:4], np % cf);
      check("auto_rand_running", r[0], 1);
    end

    // Reset in RUN, then reset in START
    reset = 1'b1;
    tick();
    check("rst_run_enable", gen_enable, 0);
    check("rst_run_reset", gen_reset, 1);
    reset = 1'b0;
    wr(ADDR_CTRL, 16'h0001);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_start_outputs", {gen_reset, gen_enable}, 2'b10);
    check("rst_start_h_vis", h_visible, 640);
    check("rst_start_pattern", pattern_sel, 0);
    check("rst_start_rd_data", bus.rd_data, 0);
    idle(8);
    check("rst_start_stays_idle", gen_enable, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
